thor2024_unblend: RTL
=====================

// Module: thor2024_unblend
// PURPOSE
//  Inverse of the Thor2024 alpha-blend op: recovers foreground c0 from blended result o, alpha a and background c1.
//  Per 10-bit channel: c0 = (o*1023 - (1023-a)*c1) / a, clamped to 0..0x3FF.
//  Two packed 10:10:10 RGB pixels per 64-bit value_t operand (bits 29:0, 61:32; bits 31:30, 63:62 pad).
//  Multi-cycle execute-stage unit; one shared iterative divider processes the 6 channels in order: b0,g0,r0,b1,g1,r1.
// PARAMETERS
//  none (channel width fixed at 10 bits by the RGB typedef)
// PORTS
//  rst      in   1   asynchronous reset, active-high
//  clk      in   1   clock; the only clock
//  req      in   1   operands valid; accepted when req && rdy
//  rdy      out  1   unit idle, can accept
//  a        in   64  alpha per channel (value_t, RGB layout)
//  c1       in   64  background colour (value_t)
//  o_in     in   64  blended colour (value_t)
//  res      out  64  recovered c0 (value_t); pad bits 0
//  res_v    out  1   res valid; held until res_ack
//  res_ack  in   1   consumer takes res when res_v && res_ack
//  div0     out  6   per-channel flag: alpha==0 {r1,g1,b1,r0,g0,b0}
//  sat      out  6   per-channel flag: quotient clamped (hi or lo), same order
// BEHAVIOUR
//  Reset: state IDLE, rdy=1, res_v=0, res=0, div0=0, sat=0, channel index 0.
//  Operands latched on accept; inputs ignored afterwards.
//  States: IDLE -> SETUP -> DIV -> (SETUP for next channel | DONE) ; DONE -> IDLE on res_ack.
//  SETUP (1 cycle): num = o*1023 - (1023-a)*c1, signed 21 bits.
//   a==0 -> channel result 0, div0 bit=1, skip DIV.
//   num<0 -> result 0, sat=1, skip DIV.
//   num >= a<<10 -> result 0x3FF, sat=1, skip DIV.
//  DIV: 10 restoring iterations, one quotient bit per cycle, MSB first; 11-bit remainder.
//  Skipped channels still spend 11 cycles (fixed latency); DIV runs idle iterations.
//  Latency: accept in cycle N -> res_v=1 in cycle N+67 (6 x 11 + 1). rdy=0 from N+1 until the cycle after the res_ack handshake.
//  res, div0, sat stable while res_v=1; res_v drops the cycle after res_ack.
//  req while busy: ignored (rdy=0); no queueing.
//  res_ack without res_v: no effect.
//  Reset mid-operation: abort immediately, all outputs to reset values, partial results discarded.
// CONFIGURATION
//  THOR2024_UNBLEND_ROUND_EN defined: SETUP adds a>>1 to num before the clamp checks and division (round to nearest).
//  Not defined: truncating quotient.
//  Latency identical either way.
// STRUCTURE
//  Thor2024pkg: value_t, RGB struct (pad[1:0], r, g, b [9:0]), localparams CH_W=10, CH_MAX=10'h3FF.
//  Sub-module thor2024_udiv10_seq: start, 21-bit dividend, 10-bit divisor, 10-bit quotient, done after 10 cycles.
//  Top level holds the FSM, channel mux, numerator arithmetic and result assembly.
// TESTING
//  1. a=all 0x3FF, c1=0x123 each channel, o=0x155 each channel
//     -> res channels 0x155, div0=0, sat=0, res_v at N+67.
//  2. a=0x200, c1=0, o=0x100 -> channel 0x1FF (truncate) / 0x200 with THOR2024_UNBLEND_ROUND_EN.
//  3. a=0x001, c1=0, o=0x3FF -> 0x3FF, sat bit=1.
//     a=0x200, c1=0x3FF, o=0 -> 0x000, sat bit=1.
//  4. a=0 on g1 only -> g1 result 0, div0=6'b010000; other channels unaffected.
//  5. Hold res_ack=0 for 20 cycles -> res_v, res, flags stable, rdy=0.
//     Second req during busy is ignored.
//  6. Assert rst at cycle N+30 -> rdy=1, res_v=0 next cycle.
//     A new request then completes correctly at +67.

Source files
------------

// File: rtl/thor2024_unblend_pkg.sv
// Shared types and helpers for the Thor2024 alpha-unblend unit.
// value_t carries two packed 10:10:10 RGB pixels.
package thor2024_unblend_pkg;

  localparam int unsigned CH_W   = 10;
  localparam int unsigned NUM_CH = 6;
  localparam logic [9:0]  CH_MAX = 10'h3FF;

  typedef logic [63:0] value_t;

  typedef struct packed {
    logic [1:0] pad;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb_t;

  typedef enum logic [1:0] {StIdle, StSetup, StDiv, StDone} state_e;

  // Bit position of channel idx in processing order b0,g0,r0,b1,g1,r1
  function automatic logic [5:0] ch_lsb(logic [2:0] idx);
    logic [5:0] pos;
    case (idx)
      3'd0:    pos = 6'd0;
      3'd1:    pos = 6'd10;
      3'd2:    pos = 6'd20;
      3'd3:    pos = 6'd32;
      3'd4:    pos = 6'd42;
      default: pos = 6'd52;
    endcase
    return pos;
  endfunction

  function automatic logic [9:0] ch_sel(value_t v, logic [2:0] idx);
    return v[ch_lsb(idx) +: CH_W];
  endfunction

endpackage

// File: rtl/thor2024_udiv10_seq.sv
// Restoring unsigned divider: 21-bit dividend / 10-bit divisor, one quotient bit per cycle.
// Quotient is presented combinationally alongside done in the 10th cycle after start.
module thor2024_udiv10_seq
  import thor2024_unblend_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] dividend,
  input  logic [9:0]  divisor,
  output logic [9:0]  quotient,
  output logic        done
);

  logic [9:0]  rem_q;
  logic [9:0]  low_q;
  logic [8:0]  quo_q;
  logic [9:0]  dvs_q;
  logic [3:0]  cnt_q;
  logic [10:0] shifted;
  logic        ge;
  logic [9:0]  rem_d;
  logic [9:0]  quo_d;

  always_comb begin
    shifted = {1'b0, rem_q, low_q[9]};
    shifted = {rem_q, low_q[9]};
    ge      = shifted >= {1'b0, dvs_q};
    // Result is below the divisor, so the low 10 bits are exact
    rem_d   = ge ? (shifted[9:0] - dvs_q) : shifted[9:0];
    quo_d   = {quo_q, ge};
    quotient = quo_d;
    done     = (cnt_q == 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      low_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      // Negative dividends are clamped upstream; treat them as zero
      rem_q <= dividend[20] ? 10'd0 : dividend[19:10];
      low_q <= dividend[20] ? 10'd0 : dividend[9:0];
      quo_q <= '0;
      dvs_q <= divisor;
      cnt_q <= 4'd10;
    end else if (cnt_q != 4'd0) begin
      rem_q <= rem_d;
      low_q <= {low_q[8:0], 1'b0};
      quo_q <= quo_d[8:0];
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: rtl/thor2024_unblend.sv
// Inverse alpha-blend: c0 = (o*1023 - (1023-a)*c1) / a per channel, clamped, fixed 67-cycle latency.
// Define THOR2024_UNBLEND_ROUND_EN to round the quotient to nearest instead of truncating.
module thor2024_unblend
  import thor2024_unblend_pkg::*;
(
  input  logic       rst,
  input  logic       clk,
  input  logic       req,
  output logic       rdy,
  input  value_t     a,
  input  value_t     c1,
  input  value_t     o_in,
  output value_t     res,
  output logic       res_v,
  input  logic       res_ack,
  output logic [5:0] div0,
  output logic [5:0] sat
);

  state_e     state_q;
  value_t     a_q, c1_q, o_q;
  logic [2:0] idx_q;
  logic       skip_q;
  logic [9:0] skip_val_q;
  rgb_t [1:0] res_q;
  logic       rdy_q, res_v_q;
  logic [5:0] div0_q, sat_q;

  logic [9:0]  ch_a, ch_c1, ch_o, inv_a, div_quo, ch_res;
  logic [19:0] prod_o, prod_c;
  logic [20:0] num;
  logic        ch_zero, num_neg, num_hi, div_start, div_done;

  always_comb begin
    ch_a    = ch_sel(a_q, idx_q);
    ch_c1   = ch_sel(c1_q, idx_q);
    ch_o    = ch_sel(o_q, idx_q);
    inv_a   = CH_MAX - ch_a;
    prod_o  = {10'd0, ch_o} * 20'd1023;
    prod_c  = {10'd0, inv_a} * {10'd0, ch_c1};
    num     = {1'b0, prod_o} - {1'b0, prod_c};
`ifdef THOR2024_UNBLEND_ROUND_EN
    num     = num + {12'd0, ch_a[9:1]};
`else
    num     = num + 21'd0;
`endif
    ch_zero = (ch_a == 10'd0);
    num_neg = num[20];
    // Quotient would exceed 10 bits
    num_hi  = !num_neg && (num[19:0] >= {ch_a, 10'd0});
    ch_res  = skip_q ? skip_val_q : div_quo;
    div_start = (state_q == StSetup);
  end

  thor2024_udiv10_seq u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num),
    .divisor  (ch_a),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      c1_q       <= '0;
      o_q        <= '0;
      idx_q      <= '0;
      skip_q     <= 1'b0;
      skip_val_q <= '0;
      res_q      <= '0;
      rdy_q      <= 1'b1;
      res_v_q    <= 1'b0;
      div0_q     <= '0;
      sat_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            a_q     <= a;
            c1_q    <= c1;
            o_q     <= o_in;
            idx_q   <= '0;
            res_q   <= '0;
            div0_q  <= '0;
            sat_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          skip_q        <= ch_zero || num_neg || num_hi;
          skip_val_q    <= (!ch_zero && num_hi) ? CH_MAX : 10'd0;
          div0_q[idx_q] <= ch_zero;
          sat_q[idx_q]  <= !ch_zero && (num_neg || num_hi);
          state_q       <= StDiv;
        end
        StDiv: begin
          if (div_done) begin
            case (idx_q)
              3'd0:    res_q[0].b <= ch_res;
              3'd1:    res_q[0].g <= ch_res;
              3'd2:    res_q[0].r <= ch_res;
              3'd3:    res_q[1].b <= ch_res;
              3'd4:    res_q[1].g <= ch_res;
              default: res_q[1].r <= ch_res;
            endcase
            if (idx_q == 3'(NUM_CH - 1)) begin
              res_v_q <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= StSetup;
            end
          end
        end
        default: begin
          if (res_ack) begin
            res_v_q <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign rdy   = rdy_q;
  assign res_v = res_v_q;
  assign res   = res_q;
  assign div0  = div0_q;
  assign sat   = sat_q;

endmodule
